// File: rtl/fft_frame_loader.sv
// Frame loader between the ADC async FIFO read side and the FFT stream input.
// Define FFT_LOADER_SIGNED_CONV_EN to convert offset-binary samples to two's complement.
module fft_frame_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAME_LEN  = 8192,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clr_status,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [13:0]           fifo_rd_water_level,
  output logic [OUT_WIDTH-1:0]  m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  underrun
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [CW-1:0] FL    = CW'(FRAME_LEN);
  localparam logic [CW-1:0] FL_M1 = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_BURST, S_FLUSH} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        issued_q, issued_d, sent_q, sent_d;
  logic                 inflight_q;
  logic [OUT_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]        occ_q, occ_d;
  logic                 frame_done_q, underrun_q;
  logic [15:0]          frame_count_q;

  logic [10:0]          sample;
  logic [OUT_WIDTH-1:0] sample_ext;
  logic [OW:0]          occ_plus;
  logic                 room, level_ok, pop, last_acc;
  logic                 unused_rd_bits;

  assign sample         = fifo_rd_data[10:0];
  assign unused_rd_bits = ^fifo_rd_data;

`ifdef FFT_LOADER_SIGNED_CONV_EN
  assign sample_ext = OUT_WIDTH'($signed({~sample[10], sample[9:0]}));
`else
  assign sample_ext = OUT_WIDTH'(sample);
`endif

  // Reads still in flight count against buffer space so a capture never overflows.
  assign occ_plus   = {1'b0, occ_q} + {{OW{1'b0}}, inflight_q};
  assign room       = occ_plus < (OW+1)'(BUF_DEPTH);
  assign level_ok   = {18'd0, fifo_rd_water_level} >= 32'(FRAME_LEN);
  assign fifo_rd_en = (state_q == S_BURST) && !fifo_empty && (issued_q < FL) && room;

  assign m_tvalid    = occ_q != '0;
  assign m_tdata     = mem_q[rd_ptr_q];
  assign m_tlast     = m_tvalid && (sent_q == FL_M1);
  assign pop         = m_tvalid && m_tready;
  assign last_acc    = pop && m_tlast;
  assign busy        = state_q != S_IDLE;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign underrun    = underrun_q;

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    occ_d    = occ_q;
    if (fifo_rd_en) issued_d = issued_q + 1'b1;
    if (pop)        sent_d   = sent_q + 1'b1;
    if (last_acc) begin
      issued_d = '0;
      sent_d   = '0;
    end
    case ({inflight_q, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    case (state_q)
      S_IDLE:  if (enable) state_d = S_ARM;
      S_ARM: begin
        if (!enable)       state_d = S_IDLE;
        else if (level_ok) state_d = S_BURST;
      end
      S_BURST: if (issued_d == FL) state_d = S_FLUSH;
      S_FLUSH: if (last_acc) state_d = enable ? S_ARM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      issued_q      <= '0;
      sent_q        <= '0;
      inflight_q    <= 1'b0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      underrun_q    <= 1'b0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      sent_q       <= sent_d;
      occ_q        <= occ_d;
      inflight_q   <= fifo_rd_en;
      frame_done_q <= last_acc;
      if (inflight_q) begin
        mem_q[wr_ptr_q] <= sample_ext;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (clr_status)    frame_count_q <= '0;
      else if (last_acc) frame_count_q <= frame_count_q + 16'd1;
      if (clr_status)
        underrun_q <= 1'b0;
      else if ((state_q == S_BURST) && (issued_q < FL) && fifo_empty)
        underrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader with an 8-sample frame and a behavioural FIFO.
module tb_fft_frame_loader;
  localparam int FL = 8;
  localparam int BD = 4;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clr_status = 1'b0;
  logic        fifo_rd_en, fifo_empty = 1'b1, m_tready = 1'b0;
  logic [15:0] fifo_rd_data = '0;
  logic [13:0] fifo_rd_water_level = '0;
  logic [15:0] m_tdata, frame_count;
  logic        m_tvalid, m_tlast, busy, frame_done, underrun;

  int total = 0, bad = 0;
  logic [10:0] fq[$];
  logic [15:0] exp_q[$];
  logic        force_empty = 1'b0;
  int          rd_total = 0, acc_total = 0, beat = 0;
  logic        prev_stall = 1'b0, prev_last_acc = 1'b0;
  logic [15:0] prev_data = '0;

  fft_frame_loader #(.DATA_WIDTH(16), .OUT_WIDTH(16), .FRAME_LEN(FL), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_status(clr_status),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rd_water_level(fifo_rd_water_level), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_of(input logic [10:0] s);
`ifdef FFT_LOADER_SIGNED_CONV_EN
    int v;
    v = int'(s) - 1024;
    return 16'(v);
`else
    return {5'd0, s};
`endif
  endfunction

  task automatic load(input int n, input int base);
    logic [10:0] s;
    for (int i = 0; i < n; i++) begin
      s = 11'((base + i) & 'h7FF);
      fq.push_back(s);
      exp_q.push_back(exp_of(s));
    end
  endtask

  // FIFO model: one-cycle read latency, flags refreshed shortly after each edge.
  always @(posedge clk) begin
    if (rst_n && fifo_rd_en) begin
      fifo_rd_data <= {5'd0, fq.pop_front()};
      rd_total++;
    end
  end

  always @(posedge clk) begin
    #2;
    fifo_empty          = force_empty || (fq.size() == 0);
    fifo_rd_water_level = 14'(fq.size());
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst_n) begin
      prev_stall    = 1'b0;
      prev_last_acc = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!m_tvalid || m_tdata !== prev_data) begin
          bad++;
          $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", m_tvalid, m_tdata, prev_data);
        end
      end
      if (frame_done || prev_last_acc) begin
        total++;
        if (frame_done !== prev_last_acc) begin
          bad++;
          $display("FAIL frame_done_pulse: got %b required %b", frame_done, prev_last_acc);
        end
      end
      if (fifo_rd_en || m_tvalid) begin
        total++;
        if (rd_total - acc_total > BD) begin
          bad++;
          $display("FAIL outstanding: got %0d required <= %0d", rd_total - acc_total, BD);
        end
      end
      if (m_tvalid && m_tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_sample: got %h required none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e) begin
            bad++;
            $display("FAIL data: got %h required %h", m_tdata, e);
          end
        end
        total++;
        if (m_tlast !== (beat == FL - 1)) begin
          bad++;
          $display("FAIL tlast: beat %0d got %b required %b", beat, m_tlast, beat == FL - 1);
        end
        acc_total++;
        prev_last_acc = (beat == FL - 1);
        beat = (beat == FL - 1) ? 0 : beat + 1;
      end else begin
        prev_last_acc = 1'b0;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  task automatic go_idle();
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({fifo_rd_en, m_tvalid, m_tlast, busy, frame_done, underrun, frame_count, m_tdata} !== '0) begin
      bad++;
      $display("FAIL reset_state: rd_en=%b valid=%b last=%b busy=%b done=%b und=%b cnt=%h data=%h required all 0",
               fifo_rd_en, m_tvalid, m_tlast, busy, frame_done, underrun, frame_count, m_tdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int first, run, nrd, vfirst, vcnt;
    bit seen;
    first = -1; run = 0; nrd = 0; vfirst = -1; vcnt = 0; seen = 0;
    @(posedge clk); #1;
    m_tready = 1'b1;
    load(FL, 0);
    enable = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        nrd++;
        if (first < 0) first = c;
        if (c == first + run) run++;
      end
      if (m_tvalid) begin
        vcnt++;
        if (vfirst < 0) vfirst = c;
      end
      if (frame_done) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL basic_done: frame_done not seen in 60 cycles"); end
    total++; if (run != FL || nrd != FL) begin bad++; $display("FAIL basic_rd_burst: consecutive=%0d total=%0d required %0d", run, nrd, FL); end
    total++; if (vfirst != first + 2) begin bad++; $display("FAIL basic_latency: valid at %0d required %0d", vfirst, first + 2); end
    total++; if (vcnt != FL) begin bad++; $display("FAIL basic_valid_cycles: got %0d required %0d", vcnt, FL); end
    total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL basic_count: got %0d required 1", frame_count); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_left: got %0d required 0", exp_q.size()); end
    go_idle();
  endtask

  task automatic test_level();
    int nrd;
    bit seen;
    nrd = 0; seen = 0;
    load(FL - 1, 'h3FC);
    enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
    end
    total++; if (nrd != 0 || busy !== 1'b1) begin bad++; $display("FAIL level7_hold: reads=%0d busy=%b required 0 and 1", nrd, busy); end
    @(posedge clk); #1;
    load(1, 'h3FC + FL - 1);
    @(negedge clk);
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL level8_early: rd_en=%b required 0", fifo_rd_en); end
    @(negedge clk);
    total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL level8_start: rd_en=%b required 1", fifo_rd_en); end
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    total++; if (!seen || frame_count !== 16'd2) begin bad++; $display("FAIL level_frame: seen=%b count=%0d required 1 and 2", seen, frame_count); end
    go_idle();
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 0;
    load(FL, 'h7F8);
    enable = 1'b1;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #1;
      m_tready = (c % 3 == 0);
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    total++; if (!seen || frame_count !== 16'd3) begin bad++; $display("FAIL bp_frame: seen=%b count=%0d required 1 and 3", seen, frame_count); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_left: got %0d required 0", exp_q.size()); end
    m_tready = 1'b1;
    go_idle();
  endtask

  task automatic test_underrun();
    int rd_base;
    bit seen;
    seen = 0;
    rd_base = rd_total;
    load(FL, 'h123);
    enable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (rd_total - rd_base >= 3) break;
    end
    force_empty = 1'b1;
    repeat (6) @(negedge clk);
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set: got %b required 1", underrun); end
    total++; if (rd_total - rd_base != 3 || fifo_rd_en !== 1'b0) begin bad++; $display("FAIL underrun_stall: reads=%0d rd_en=%b required 3 and 0", rd_total - rd_base, fifo_rd_en); end
    @(posedge clk); #1;
    force_empty = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    total++; if (!seen || rd_total - rd_base != FL) begin bad++; $display("FAIL underrun_resume: seen=%b reads=%0d required 1 and %0d", seen, rd_total - rd_base, FL); end
    total++; if (underrun !== 1'b1 || frame_count !== 16'd4) begin bad++; $display("FAIL underrun_sticky: und=%b count=%0d required 1 and 4", underrun, frame_count); end
    @(posedge clk); #1;
    clr_status = 1'b1;
    @(posedge clk); #1;
    clr_status = 1'b0;
    @(negedge clk);
    total++; if (underrun !== 1'b0 || frame_count !== 16'd0) begin bad++; $display("FAIL clr_status: und=%b count=%0d required 0 and 0", underrun, frame_count); end
    go_idle();
  endtask

  task automatic test_enable_drop();
    int rd_base, acc_base;
    bit seen;
    logic [15:0] fc;
    seen = 0; fc = 16'hFFFF;
    rd_base = rd_total; acc_base = acc_total;
    load(2 * FL, 'h200);
    enable = 1'b1;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk); #1;
      clr_status = 1'b0;
      if (acc_total - acc_base >= 2) enable = 1'b0;
      if (m_tvalid && m_tlast) clr_status = 1'b1;
      @(negedge clk);
      if (frame_done) begin seen = 1; fc = frame_count; end
    end
    @(posedge clk); #1;
    clr_status = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (!seen || fc !== 16'd0) begin bad++; $display("FAIL clr_vs_done: seen=%b count=%0d required 1 and 0", seen, fc); end
    total++; if (busy !== 1'b0 || fifo_rd_water_level < 14'(FL)) begin bad++; $display("FAIL en_drop_idle: busy=%b level=%0d required 0 and >=%0d", busy, fifo_rd_water_level, FL); end
    total++; if (rd_total - rd_base != FL || exp_q.size() != FL) begin bad++; $display("FAIL en_drop_len: reads=%0d left=%0d required %0d and %0d", rd_total - rd_base, exp_q.size(), FL, FL); end
    fq.delete();
    exp_q.delete();
    go_idle();
  endtask

  task automatic test_reset_mid();
    int acc_base;
    bit seen;
    seen = 0;
    acc_base = acc_total;
    load(FL, 'h050);
    enable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (acc_total - acc_base >= 4) break;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({fifo_rd_en, m_tvalid, m_tlast, busy, frame_done, underrun, frame_count, m_tdata} !== '0) begin
      bad++;
      $display("FAIL reset_mid: rd_en=%b valid=%b last=%b busy=%b done=%b cnt=%h data=%h required all 0",
               fifo_rd_en, m_tvalid, m_tlast, busy, frame_done, frame_count, m_tdata);
    end
    fq.delete(); exp_q.delete();
    beat = 0; rd_total = 0; acc_total = 0; enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    load(FL, 0);
    enable = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    total++; if (!seen || frame_count !== 16'd1) begin bad++; $display("FAIL reset_fresh: seen=%b count=%0d required 1 and 1", seen, frame_count); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL reset_left: got %0d required 0", exp_q.size()); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level();
    test_backpressure();
    test_underrun();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end
endmodule
